// File: rtl/pe_uno_iter_if.sv
// Bundle of the data/handshake signals of pe_uno_iter.
// slave  : PE side (drives results, forwarded operands and status)
// master : environment side (drives operands, job control and coefficient table reads)
// Signals:
//   mode_i, in_valid_i, x_i, wc_i, o_i            GEMM operands and upstream partial sum
//   start_i, iter_i, mac_i                         unary job control and initial value
//   coef_scale_i, coef_offset_i                    per-step coefficients for iter_idx_o
//   sat_clr_i                                      clears sticky saturation flag
//   wc_o, x_o, o_o, o_valid_o                      forwarded operands and result
//   busy_o, done_o, iter_idx_o, sat_o              status
interface pe_uno_iter_if #(
    parameter int unsigned MUL_BW  = 16,
    parameter int unsigned ACC_BW  = 32,
    parameter int unsigned ITER_BW = 4
);
    logic [1:0]         mode_i;
    logic               in_valid_i;
    logic [MUL_BW-1:0]  x_i;
    logic [MUL_BW-1:0]  wc_i;
    logic [ACC_BW-1:0]  o_i;
    logic               start_i;
    logic [ITER_BW-1:0] iter_i;
    logic [ACC_BW-1:0]  mac_i;
    logic [MUL_BW-1:0]  coef_scale_i;
    logic [ACC_BW-1:0]  coef_offset_i;
    logic               sat_clr_i;
    logic [MUL_BW-1:0]  wc_o;
    logic [MUL_BW-1:0]  x_o;
    logic [ACC_BW-1:0]  o_o;
    logic               o_valid_o;
    logic               busy_o;
    logic               done_o;
    logic [ITER_BW-1:0] iter_idx_o;
    logic               sat_o;

    modport slave (
        input  mode_i, in_valid_i, x_i, wc_i, o_i, start_i, iter_i, mac_i,
               coef_scale_i, coef_offset_i, sat_clr_i,
        output wc_o, x_o, o_o, o_valid_o, busy_o, done_o, iter_idx_o, sat_o
    );

    modport master (
        output mode_i, in_valid_i, x_i, wc_i, o_i, start_i, iter_i, mac_i,
               coef_scale_i, coef_offset_i, sat_clr_i,
        input  wc_o, x_o, o_o, o_valid_o, busy_o, done_o, iter_idx_o, sat_o
    );
endinterface

// File: rtl/pe_uno_iter.sv
// Reconfigurable systolic PE.
//   mode 00: GEMM MAC, o_o <= sat(wc*x + o_i), 2-cycle latency, one operand pair per cycle.
//   mode 01/10/11: iterative unary job, acc <= sat(T(acc)*scale_k + offset_k) for N steps,
//   coefficients read combinationally from an external table addressed by iter_idx_o.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         pe_uno_iter_if slave modport (operands, job control, results, status)
module pe_uno_iter #(
    parameter int unsigned INT_BW   = 5,
    parameter int unsigned FRA_BW   = 10,
    parameter int unsigned MUL_BW   = 16,
    parameter int unsigned ACC_BW   = 32,
    parameter int unsigned ITER_MAX = 8,
    parameter int unsigned ITER_BW  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pe_uno_iter_if.slave bus
);
    localparam int unsigned OpBw   = 1 + INT_BW + FRA_BW;
    localparam int unsigned ProdBw = 2 * MUL_BW;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                    state_q;
    logic signed [MUL_BW-1:0]  wreg_q, ireg_q;
    logic                      v1_q;
    logic signed [ACC_BW-1:0]  acc_q, o_q;
    logic                      o_valid_q, done_q, sat_q, sat_d;
    logic [ITER_BW-1:0]        k_q, n_q, n_in;

    logic                      run;
    logic signed [ACC_BW-1:0]  acc_sh;
    logic [ACC_BW-OpBw:0]      acc_hi;
    logic signed [MUL_BW-1:0]  trunc;
    logic                      tr_sat;
    logic signed [MUL_BW-1:0]  op_a, op_b;
    logic signed [ACC_BW-1:0]  addend;
    logic signed [ProdBw-1:0]  prod;
    logic [ACC_BW:0]           sum;
    logic                      add_sat;
    logic signed [ACC_BW-1:0]  mac_res;

    assign run  = (state_q == StRun);
    assign n_in = (bus.iter_i > ITER_BW'(ITER_MAX)) ? ITER_BW'(ITER_MAX) : bus.iter_i;

    // Saturating truncation of the accumulator back to the multiplier operand format.
    always_comb begin
        acc_sh = acc_q >>> FRA_BW;
        acc_hi = acc_sh[ACC_BW-1:OpBw-1];
        tr_sat = 1'b0;
        trunc  = acc_sh[MUL_BW-1:0];
        if (!((&acc_hi) || !(|acc_hi))) begin
            tr_sat = 1'b1;
            trunc  = {acc_sh[ACC_BW-1], {(MUL_BW-1){~acc_sh[ACC_BW-1]}}};
        end
    end

    // One shared MAC: a GEMM stage-2 operation only ever occurs while the FSM is idle,
    // so the unary loop and the GEMM pipeline never contend for it.
    always_comb begin
        op_a    = run ? trunc : wreg_q;
        op_b    = run ? bus.coef_scale_i : ireg_q;
        addend  = run ? bus.coef_offset_i : bus.o_i;
        prod    = ProdBw'(op_a) * ProdBw'(op_b);
        sum     = {{(ACC_BW + 1 - ProdBw){prod[ProdBw-1]}}, prod} + {addend[ACC_BW-1], addend};
        add_sat = (sum[ACC_BW] != sum[ACC_BW-1]);
        mac_res = add_sat ? {sum[ACC_BW], {(ACC_BW-1){~sum[ACC_BW]}}} : sum[ACC_BW-1:0];
    end

    // Sticky saturation: a new event wins over a same-cycle clear.
    always_comb begin
        sat_d = sat_q && !bus.sat_clr_i;
        if ((run && (tr_sat || add_sat)) || (v1_q && add_sat)) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wreg_q    <= '0;
            ireg_q    <= '0;
            v1_q      <= 1'b0;
            acc_q     <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
            k_q       <= '0;
            n_q       <= '0;
        end else begin
            sat_q     <= sat_d;
            v1_q      <= 1'b0;
            o_valid_q <= 1'b0;
            done_q    <= 1'b0;
            if (v1_q) begin
                o_q       <= mac_res;
                o_valid_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i && bus.mode_i != 2'b00) begin
                        acc_q <= bus.mac_i;
                        k_q   <= '0;
                        n_q   <= n_in;
                        if (n_in == '0) begin
                            // Zero-step job; its result overrides a GEMM result
                            // landing on the same edge.
                            state_q   <= StDone;
                            o_q       <= bus.mac_i;
                            o_valid_q <= 1'b1;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end else if (bus.in_valid_i && bus.mode_i == 2'b00) begin
                        wreg_q <= bus.wc_i;
                        ireg_q <= bus.x_i;
                        v1_q   <= 1'b1;
                    end
                end
                StRun: begin
                    acc_q <= mac_res;
                    k_q   <= k_q + ITER_BW'(1);
                    if (k_q == n_q - ITER_BW'(1)) begin
                        state_q   <= StDone;
                        o_q       <= mac_res;
                        o_valid_q <= 1'b1;
                        done_q    <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.wc_o       = wreg_q;
    assign bus.x_o        = ireg_q;
    assign bus.o_o        = o_q;
    assign bus.o_valid_o  = o_valid_q;
    assign bus.busy_o     = (state_q != StIdle);
    assign bus.done_o     = done_q;
    assign bus.iter_idx_o = k_q;
    assign bus.sat_o      = sat_q;
endmodule
